lifcl_slice_reg: RTL and testbench

LIFCL_SLICE_REG -- requirements
Module: lifcl_slice_reg

---
 rtl/lifcl_slice_pkg.sv | 48 ++++
 rtl/lifcl_slice_ff.sv | 54 +++++
 rtl/lifcl_slice_reg.sv | 82 ++++++++
 tb/tb_lifcl_slice_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lifcl_slice_pkg.sv
// Shared types and elaboration-time helpers for the two-bit slice register.
// String parameters are decoded into enums once, at the top level.
package lifcl_slice_pkg;

  typedef enum logic {REGSET_RESET, REGSET_SET} regset_e;
  typedef enum logic {SEL_DF, SEL_DL} sel_e;
  typedef enum logic {LSRMODE_LSR, LSRMODE_PRLD} lsrmode_e;
  typedef enum logic {SRMODE_LSR_OVER_CE, SRMODE_ASYNC} srmode_e;
  typedef enum logic {GSR_ENABLED, GSR_DISABLED} gsr_e;
  typedef enum logic {CLKMUX_CLK, CLKMUX_INV} clkmux_e;
  typedef enum logic [1:0] {CEMUX_CE, CEMUX_INV, CEMUX_ONE} cemux_e;

  function automatic regset_e decode_regset(string s);
    return (s == "SET") ? REGSET_SET : REGSET_RESET;
  endfunction

  function automatic sel_e decode_sel(string s);
    return (s == "DL") ? SEL_DL : SEL_DF;
  endfunction

  function automatic lsrmode_e decode_lsrmode(string s);
    return (s == "PRLD") ? LSRMODE_PRLD : LSRMODE_LSR;
  endfunction

  function automatic srmode_e decode_srmode(string s);
    return (s == "ASYNC") ? SRMODE_ASYNC : SRMODE_LSR_OVER_CE;
  endfunction

  function automatic gsr_e decode_gsr(string s);
    return (s == "DISABLED") ? GSR_DISABLED : GSR_ENABLED;
  endfunction

  function automatic clkmux_e decode_clkmux(string s);
    return (s == "INV") ? CLKMUX_INV : CLKMUX_CLK;
  endfunction

  function automatic cemux_e decode_cemux(string s);
    if (s == "INV") return CEMUX_INV;
    if (s == "1") return CEMUX_ONE;
    return CEMUX_CE;
  endfunction

  // Value forced by any reset condition
  function automatic logic regset_value(regset_e r);
    return (r == REGSET_SET);
  endfunction

endpackage

// File: rtl/lifcl_slice_ff.sv
// One slice register bit: RST > GSRI > async LSR > sync LSR > CE capture > hold.
// Every asynchronous source forces the same value, so they share one clear/preset input.
module lifcl_slice_ff
  import lifcl_slice_pkg::*;
#(
  parameter logic     INIT      = 1'b0,
  parameter sel_e     SEL_P     = SEL_DF,
  parameter lsrmode_e LSRMODE_P = LSRMODE_LSR,
  parameter srmode_e  SRMODE_P  = SRMODE_LSR_OVER_CE,
  parameter gsr_e     GSR_P     = GSR_ENABLED,
  parameter clkmux_e  CLKMUX_P  = CLKMUX_CLK,
  parameter cemux_e   CEMUX_P   = CEMUX_CE
) (
  input  logic clk,
  input  logic rst,
  input  logic gsri,
  input  logic ce,
  input  logic lsr,
  input  logic di,
  input  logic m,
  output logic q
);

  logic clk_eff;
  logic arst;
  logic ce_eff;
  logic sync_lsr;
  logic sync_val;
  logic d;

  assign clk_eff  = (CLKMUX_P == CLKMUX_INV) ? ~clk : clk;
  assign arst     = rst
                  | ((GSR_P == GSR_ENABLED) & gsri)
                  | ((SRMODE_P == SRMODE_ASYNC) & lsr);
  assign sync_lsr = (SRMODE_P == SRMODE_LSR_OVER_CE) & lsr;
  assign sync_val = (LSRMODE_P == LSRMODE_PRLD) ? m : INIT;
  assign d        = (SEL_P == SEL_DL) ? m : di;

  always_comb begin
    ce_eff = ce;
    case (CEMUX_P)
      CEMUX_INV: ce_eff = ~ce;
      CEMUX_ONE: ce_eff = 1'b1;
      default:   ce_eff = ce;
    endcase
  end

  always_ff @(posedge clk_eff or posedge arst) begin
    if (arst)          q <= INIT;
    else if (sync_lsr) q <= sync_val;
    else if (ce_eff)   q <= d;
  end

endmodule

// File: rtl/lifcl_slice_reg.sv
// Two-register logic slice sharing clock, enable and local set/reset.
// Parameter strings are validated here; illegal settings stop elaboration.
module lifcl_slice_reg
  import lifcl_slice_pkg::*;
#(
  parameter string REGSET0 = "RESET",
  parameter string REGSET1 = "RESET",
  parameter string SEL     = "DF",
  parameter string LSRMODE = "LSR",
  parameter string SRMODE  = "LSR_OVER_CE",
  parameter string GSR     = "ENABLED",
  parameter string CLKMUX  = "CLK",
  parameter string CEMUX   = "CE"
) (
  input  logic CLK,
  input  logic RST,
  input  logic GSRI,
  input  logic CE,
  input  logic LSR,
  input  logic DI0,
  input  logic DI1,
  input  logic M0,
  input  logic M1,
  output logic Q0,
  output logic Q1
);

  localparam regset_e  RS0 = decode_regset(REGSET0);
  localparam regset_e  RS1 = decode_regset(REGSET1);
  localparam sel_e     SL  = decode_sel(SEL);
  localparam lsrmode_e LM  = decode_lsrmode(LSRMODE);
  localparam srmode_e  SM  = decode_srmode(SRMODE);
  localparam gsr_e     GM  = decode_gsr(GSR);
  localparam clkmux_e  CKM = decode_clkmux(CLKMUX);
  localparam cemux_e   CEM = decode_cemux(CEMUX);

  if (!(REGSET0 == "RESET" || REGSET0 == "SET")) begin : g_bad_regset0
    $error("lifcl_slice_reg: REGSET0 must be RESET or SET");
  end
  if (!(REGSET1 == "RESET" || REGSET1 == "SET")) begin : g_bad_regset1
    $error("lifcl_slice_reg: REGSET1 must be RESET or SET");
  end
  if (!(SEL == "DF" || SEL == "DL")) begin : g_bad_sel
    $error("lifcl_slice_reg: SEL must be DF or DL");
  end
  if (!(LSRMODE == "LSR" || LSRMODE == "PRLD")) begin : g_bad_lsrmode
    $error("lifcl_slice_reg: LSRMODE must be LSR or PRLD");
  end
  if (!(SRMODE == "LSR_OVER_CE" || SRMODE == "ASYNC")) begin : g_bad_srmode
    $error("lifcl_slice_reg: SRMODE must be LSR_OVER_CE or ASYNC");
  end
  if (!(GSR == "ENABLED" || GSR == "DISABLED")) begin : g_bad_gsr
    $error("lifcl_slice_reg: GSR must be ENABLED or DISABLED");
  end
  if (!(CLKMUX == "CLK" || CLKMUX == "INV")) begin : g_bad_clkmux
    $error("lifcl_slice_reg: CLKMUX must be CLK or INV");
  end
  if (!(CEMUX == "CE" || CEMUX == "INV" || CEMUX == "1")) begin : g_bad_cemux
    $error("lifcl_slice_reg: CEMUX must be CE, INV or 1");
  end
  // An asynchronous preload would need a data-dependent async set/clear
  if (SRMODE == "ASYNC" && LSRMODE == "PRLD") begin : g_bad_async_prld
    $error("lifcl_slice_reg: SRMODE=ASYNC cannot be combined with LSRMODE=PRLD");
  end

  lifcl_slice_ff #(
    .INIT(regset_value(RS0)), .SEL_P(SL), .LSRMODE_P(LM), .SRMODE_P(SM),
    .GSR_P(GM), .CLKMUX_P(CKM), .CEMUX_P(CEM)
  ) u_ff0 (
    .clk(CLK), .rst(RST), .gsri(GSRI), .ce(CE), .lsr(LSR),
    .di(DI0), .m(M0), .q(Q0)
  );

  lifcl_slice_ff #(
    .INIT(regset_value(RS1)), .SEL_P(SL), .LSRMODE_P(LM), .SRMODE_P(SM),
    .GSR_P(GM), .CLKMUX_P(CKM), .CEMUX_P(CEM)
  ) u_ff1 (
    .clk(CLK), .rst(RST), .gsri(GSRI), .ce(CE), .lsr(LSR),
    .di(DI1), .m(M1), .q(Q1)
  );

endmodule

// File: tb/tb_lifcl_slice_reg.sv
// Directed bench for lifcl_slice_reg: five configurations share one stimulus bus,
// a vector table exercises the default sync path, hand sequences cover the corners.
module tb_lifcl_slice_reg;

  logic clk = 1'b0, rst = 1'b1, gsri = 1'b0, ce = 1'b0, lsr = 1'b0;
  logic di0 = 1'b0, di1 = 1'b0, m0 = 1'b0, m1 = 1'b0;
  logic qa0, qa1, qb0, qb1, qc0, qc1, qd0, qd1, qf0, qf1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // a: SET/RESET, defaults otherwise
  lifcl_slice_reg #(.REGSET0("SET"), .REGSET1("RESET")) u_a (
    .CLK(clk), .RST(rst), .GSRI(gsri), .CE(ce), .LSR(lsr),
    .DI0(di0), .DI1(di1), .M0(m0), .M1(m1), .Q0(qa0), .Q1(qa1));
  // b: asynchronous LSR
  lifcl_slice_reg #(.REGSET0("RESET"), .REGSET1("SET"), .SRMODE("ASYNC")) u_b (
    .CLK(clk), .RST(rst), .GSRI(gsri), .CE(ce), .LSR(lsr),
    .DI0(di0), .DI1(di1), .M0(m0), .M1(m1), .Q0(qb0), .Q1(qb1));
  // c: synchronous preload
  lifcl_slice_reg #(.LSRMODE("PRLD")) u_c (
    .CLK(clk), .RST(rst), .GSRI(gsri), .CE(ce), .LSR(lsr),
    .DI0(di0), .DI1(di1), .M0(m0), .M1(m1), .Q0(qc0), .Q1(qc1));
  // d: GSRI ignored
  lifcl_slice_reg #(.GSR("DISABLED"), .REGSET1("RESET")) u_d (
    .CLK(clk), .RST(rst), .GSRI(gsri), .CE(ce), .LSR(lsr),
    .DI0(di0), .DI1(di1), .M0(m0), .M1(m1), .Q0(qd0), .Q1(qd1));
  // f: falling edge, active-low CE, bypass data
  lifcl_slice_reg #(.CLKMUX("INV"), .CEMUX("INV"), .SEL("DL")) u_f (
    .CLK(clk), .RST(rst), .GSRI(gsri), .CE(ce), .LSR(lsr),
    .DI0(di0), .DI1(di1), .M0(m0), .M1(m1), .Q0(qf0), .Q1(qf1));

  typedef struct {
    logic       ce, lsr, di0, di1, m0, m1;
    logic [1:0] exp;   // {Q0, Q1} of u_a after the edge
  } vec_t;

  vec_t tbl [10];

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fall();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            ce  lsr di0 di1 m0  m1  exp
    tbl[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01};
    tbl[1] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01};
    tbl[2] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10};
    tbl[3] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b11};
    tbl[4] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10};
    tbl[5] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00};
    tbl[6] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b10};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01};
    tbl[8] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b01};
    tbl[9] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b11};

    #1;
    check2("reset_a", {qa0, qa1}, 2'b10);
    check2("reset_b", {qb0, qb1}, 2'b01);
    check2("reset_f", {qf0, qf1}, 2'b00);
    step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ce = tbl[i].ce; lsr = tbl[i].lsr;
      di0 = tbl[i].di0; di1 = tbl[i].di1;
      m0 = tbl[i].m0; m1 = tbl[i].m1;
      step();
      check2($sformatf("vec%0d", i), {qa0, qa1}, tbl[i].exp);
    end

    // RST pulse mid-cycle acts immediately, release is silent, next edge captures
    ce = 1'b0;
    #1 rst = 1'b1;
    #1 check2("rst_async_a", {qa0, qa1}, 2'b10);
    rst = 1'b0;
    #1 check2("rst_release_a", {qa0, qa1}, 2'b10);
    ce = 1'b1; di0 = 1'b0; di1 = 1'b1;
    step();
    check2("rst_then_capture_a", {qa0, qa1}, 2'b01);

    // asynchronous LSR clears before the edge and dominates capture
    di0 = 1'b1;
    step();
    check1("b_capture", qb0, 1'b1);
    #3 lsr = 1'b1;
    #1 check1("b_async_lsr", qb0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check1($sformatf("b_lsr_hold%0d", i), qb0, 1'b0);
    end
    lsr = 1'b0;
    #1 check1("b_lsr_release", qb0, 1'b0);
    step();
    check1("b_after_release", qb0, 1'b1);

    // synchronous preload ignores CE and waits for the edge
    di0 = 1'b0; di1 = 1'b1;
    step();
    check2("c_capture", {qc0, qc1}, 2'b01);
    ce = 1'b0; lsr = 1'b1; m0 = 1'b1; m1 = 1'b0;
    fall();
    check2("c_before_edge", {qc0, qc1}, 2'b01);
    step();
    check2("c_preload", {qc0, qc1}, 2'b10);
    lsr = 1'b0; ce = 1'b1; di0 = 1'b0; di1 = 1'b1;

    // GSRI: honoured by u_a, ignored by u_d
    step();
    check1("a_q1_set", qa1, 1'b1);
    check1("d_q1_set", qd1, 1'b1);
    ce = 1'b0;
    #2 gsri = 1'b1;
    #1 check1("d_gsri_ignored", qd1, 1'b1);
    check2("a_gsri_async", {qa0, qa1}, 2'b10);
    ce = 1'b1;
    step();
    check2("a_gsri_over_edge", {qa0, qa1}, 2'b10);
    check2("d_gsri_capture", {qd0, qd1}, 2'b01);
    gsri = 1'b0;
    #1 check2("a_gsri_release", {qa0, qa1}, 2'b10);
    step();
    check2("a_after_gsri", {qa0, qa1}, 2'b01);

    // falling-edge register with active-low CE and bypass data
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    check2("f_reset", {qf0, qf1}, 2'b00);
    fall();
    ce = 1'b0; m0 = 1'b1; m1 = 1'b1; di0 = 1'b0; di1 = 1'b0;
    step();
    check2("f_no_posedge", {qf0, qf1}, 2'b00);
    fall();
    check2("f_negedge_capture", {qf0, qf1}, 2'b11);
    ce = 1'b1; m0 = 1'b0; m1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fall();
      check2($sformatf("f_ce_hold%0d", i), {qf0, qf1}, 2'b11);
    end
    ce = 1'b0;
    fall();
    check2("f_reenable", {qf0, qf1}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
